// File: rtl/mem_link_responder.sv
// ============================================================================
// Module   : mem_link_responder
// Purpose  : Edge-port responder that executes echo, write and read link
//            requests against a small register file and returns one response
//            flit per request. Optional macro MEM_LINK_RESPONDER_ERR_RESP_EN
//            enables error responses and err_o for op 11.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_link_responder #(
    parameter  int ENTRIES    = 4,
    parameter  int FIFO_DEPTH = 2,
    localparam int LINK_W     = 68
) (
    input  logic              clk_i,
    input  logic              reset_n_i,
    input  logic [LINK_W-1:0] link_i,
    output logic [LINK_W-1:0] link_o,
    output logic              busy_o
`ifdef MEM_LINK_RESPONDER_ERR_RESP_EN
    ,
    output logic              err_o
`endif
);

    localparam int IDX_W  = $clog2(ENTRIES);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int DATA_W = LINK_W - 2;

    localparam logic [1:0] OP_ECHO  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_RSV   = 2'b11;

    logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic              rdy_q;
    logic              full_d;
    logic              resp_v_q;
    logic [DATA_W-1:0] resp_data_q;
    logic [31:0]       rf_q [ENTRIES];

    logic              empty;
    logic              enq;
    logic              exec;
    logic [DATA_W-1:0] head;
    logic [1:0]        head_op;
    logic [31:0]       head_val;
    logic [31:0]       head_addr;
    logic [IDX_W-1:0]  head_idx;
    logic [31:0]       head_rdata;
    logic [31:0]       resp_word;

    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        enq        = link_i[67] & rdy_q;
        // The head may execute while the response register drains this edge.
        exec       = !empty & (!resp_v_q | link_i[66]);
        head       = fifo_q[rd_ptr_q[PTR_W-1:0]];
        head_op    = head[65:64];
        head_val   = head[63:32];
        head_addr  = head[31:0];
        head_idx   = head_addr[IDX_W-1:0];
        head_rdata = rf_q[head_idx];
        resp_word  = head_val;
        case (head_op)
            OP_ECHO, OP_WRITE: resp_word = head_val;
            OP_READ:           resp_word = head_rdata;
            OP_RSV: begin
`ifdef MEM_LINK_RESPONDER_ERR_RESP_EN
                resp_word = 32'hDEAD_BEEF;
`else
                resp_word = head_val;
`endif
            end
        endcase
        wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, enq};
        rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, exec};
        full_d   = (wr_ptr_d[PTR_W] != rd_ptr_d[PTR_W]) &&
                   (wr_ptr_d[PTR_W-1:0] == rd_ptr_d[PTR_W-1:0]);
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            fifo_q[wr_ptr_q[PTR_W-1:0]] <= link_i[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rdy_q       <= 1'b0;
            resp_v_q    <= 1'b0;
            resp_data_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            // Ready is the registered not-full view, so a full FIFO never enqueues.
            rdy_q    <= !full_d;
            if (exec) begin
                resp_v_q    <= 1'b1;
                resp_data_q <= {head_op, resp_word, head_addr};
                if (head_op == OP_WRITE) begin
                    rf_q[head_idx] <= head_val;
                end
            end else if (link_i[66]) begin
                resp_v_q <= 1'b0;
            end
        end
    end

`ifdef MEM_LINK_RESPONDER_ERR_RESP_EN
    logic err_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            err_q <= 1'b0;
        end else begin
            err_q <= exec && (head_op == OP_RSV);
        end
    end

    assign err_o = err_q;
`endif

    assign link_o = {resp_v_q, rdy_q, resp_data_q};
    assign busy_o = !empty | resp_v_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_link_responder.sv
// ============================================================================
// Module   : tb_mem_link_responder
// Purpose  : Directed and randomized checks of mem_link_responder against a
//            queue-based behavioural model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_link_responder;

    localparam int ENTRIES    = 4;
    localparam int FIFO_DEPTH = 2;
`ifdef MEM_LINK_RESPONDER_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n_i;
    logic [67:0] link_i;
    logic [67:0] link_o;
    logic        busy_o;
`ifdef MEM_LINK_RESPONDER_ERR_RESP_EN
    logic        err_o;
`endif

    mem_link_responder #(
        .ENTRIES    (ENTRIES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk_i     (clk),
        .reset_n_i (reset_n_i),
        .link_i    (link_i),
        .link_o    (link_o),
        .busy_o    (busy_o)
`ifdef MEM_LINK_RESPONDER_ERR_RESP_EN
        ,
        .err_o     (err_o)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: request queue, one response slot, register file.
    logic [65:0] fq [$];
    logic        mv, mrdy, merr;
    logic [65:0] md;
    logic [31:0] mrf [ENTRIES];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          n_acc = 0;

    function automatic logic [65:0] req(input logic [1:0] op, input logic [31:0] val,
                                        input logic [31:0] addr);
        return {op, val, addr};
    endfunction

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        fq.delete();
        mv   = 1'b0;
        mrdy = 1'b0;
        merr = 1'b0;
        md   = '0;
        for (int i = 0; i < ENTRIES; i++) mrf[i] = '0;
    endtask

    task automatic model_edge(input bit v, input bit rr, input logic [65:0] d);
        bit          enq;
        bit          ex;
        logic [65:0] h;
        logic [1:0]  op;
        logic [31:0] val, addr, w;
        int          idx;
        enq  = v && mrdy;
        ex   = (fq.size() > 0) && (!mv || rr);
        merr = 1'b0;
        if (ex) begin
            h    = fq.pop_front();
            op   = h[65:64];
            val  = h[63:32];
            addr = h[31:0];
            idx  = int'(addr % ENTRIES);
            w    = val;
            if (op == 2'b10) w = mrf[idx];
            if (op == 2'b01) mrf[idx] = val;
            if (op == 2'b11 && ERR_EN) begin
                w    = 32'hDEAD_BEEF;
                merr = 1'b1;
            end
            md = {op, w, addr};
            mv = 1'b1;
        end else if (rr) begin
            mv = 1'b0;
        end
        if (enq) fq.push_back(d);
        mrdy = (fq.size() < FIFO_DEPTH);
    endtask

    task automatic cyc(input bit v, input bit rr, input logic [65:0] d);
        link_i = {v, rr, d};
        if (v && link_o[66]) n_acc++;
        @(posedge clk);
        model_edge(v, rr, d);
        @(negedge clk);
        check("link_o", link_o, {mv, mrdy, md});
        check("busy", {67'd0, busy_o}, {67'd0, (fq.size() != 0) || mv});
`ifdef MEM_LINK_RESPONDER_ERR_RESP_EN
        check("err", {67'd0, err_o}, {67'd0, merr});
`endif
    endtask

    initial begin
        logic [31:0] rv;
        reset_n_i = 1'b0;
        link_i    = '0;
        model_reset();
        @(negedge clk);
        check("reset_link", link_o, 68'h0);
        check("reset_busy", {67'd0, busy_o}, 68'h0);
        reset_n_i = 1'b1;
        cyc(0, 1, '0);
        check("ready_after_reset", {67'd0, link_o[66]}, 68'h1);

        // Write then read-back on consecutive cycles.
        cyc(1, 1, req(2'b01, 32'h1234_5678, 32'd2));
        check("wr_not_yet", {67'd0, link_o[67]}, 68'h0);
        cyc(1, 1, req(2'b10, 32'h0, 32'd2));
        check("wr_resp", {link_o[67], 1'b0, link_o[65:0]},
              {1'b1, 1'b0, 2'b01, 32'h1234_5678, 32'd2});
        cyc(0, 1, '0);
        check("rd_resp", {link_o[67], 1'b0, link_o[65:0]},
              {1'b1, 1'b0, 2'b10, 32'h1234_5678, 32'd2});
        repeat (2) cyc(0, 1, '0);

        // Back-pressure: five echoes with the reverse link stalled.
        n_acc = 0;
        for (int i = 0; i < 5; i++) cyc(1, 0, req(2'b00, 32'hA0 + i, 32'h10 + i));
        check("bp_accepted", n_acc, 68'd3);
        check("bp_ready_low", {67'd0, link_o[66]}, 68'h0);
        check("bp_first", {link_o[67], 1'b0, link_o[65:0]},
              {1'b1, 1'b0, 2'b00, 32'hA0, 32'h10});
        for (int i = 0; i < 4; i++) cyc(0, 1, '0);

        // Upper address bits are ignored for indexing.
        rv = $urandom() | 32'h1;
        cyc(1, 1, req(2'b01, rv, 32'd5));
        cyc(1, 1, req(2'b10, 32'h0, 32'hFFFF_FFF1));
        cyc(0, 1, '0);
        check("alias_read", {2'b00, link_o[65:0]}, {2'b00, 2'b10, rv, 32'hFFFF_FFF1});
        repeat (2) cyc(0, 1, '0);

        // Asynchronous reset with queued requests and a pending response.
        for (int i = 0; i < 3; i++) cyc(1, 0, req(2'b01, 32'h55 + i, i));
        check("pre_reset_valid", {67'd0, link_o[67]}, 68'h1);
        link_i = '0;
        #2 reset_n_i = 1'b0;
        #1;
        check("async_reset_link", link_o, 68'h0);
        check("async_reset_busy", {67'd0, busy_o}, 68'h0);
        model_reset();
        @(negedge clk);
        reset_n_i = 1'b1;
        repeat (3) cyc(0, 1, '0);
        cyc(1, 1, req(2'b10, 32'h0, $urandom()));
        repeat (2) cyc(0, 1, '0);

        // Reserved op.
        cyc(1, 1, req(2'b11, 32'd7, 32'd9));
        cyc(0, 1, '0);
        check("rsv_value", {36'd0, link_o[63:32]}, {36'd0, (ERR_EN ? 32'hDEAD_BEEF : 32'd7)});
        cyc(0, 1, '0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            cyc($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                req(2'($urandom_range(0, 3)), $urandom(), $urandom()));
        end
        repeat (5) cyc(0, 1, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
